vta_host_axil_master: RTL and testbench

//  Host-side bridge directly downstream of the host DPI request source. Accepts one

---
 rtl/vta_host_axil_master_if.sv | 38 +++
 rtl/vta_host_axil_master.sv | 143 ++++++++++++++
 tb/tb_vta_host_axil_master.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vta_host_axil_master_if.sv
// AXI4-Lite channel bundle between the host request bridge (master) and the
// accelerator control-register block (slave).
interface vta_host_axil_master_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32
);
    logic                     m_awvalid;
    logic                     m_awready;
    logic [ADDR_BITS-1:0]     m_awaddr;
    logic                     m_wvalid;
    logic                     m_wready;
    logic [DATA_BITS-1:0]     m_wdata;
    logic [DATA_BITS/8-1:0]   m_wstrb;
    logic                     m_bvalid;
    logic                     m_bready;
    logic [1:0]               m_bresp;
    logic                     m_arvalid;
    logic                     m_arready;
    logic [ADDR_BITS-1:0]     m_araddr;
    logic                     m_rvalid;
    logic                     m_rready;
    logic [DATA_BITS-1:0]     m_rdata;
    logic [1:0]               m_rresp;

    modport master (
        output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
               m_arvalid, m_araddr, m_rready,
        input  m_awready, m_wready, m_bvalid, m_bresp, m_arready,
               m_rvalid, m_rdata, m_rresp
    );

    modport slave (
        input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
               m_arvalid, m_araddr, m_rready,
        output m_awready, m_wready, m_bvalid, m_bresp, m_arready,
               m_rvalid, m_rdata, m_rresp
    );
endinterface

// File: rtl/vta_host_axil_master.sv
// Host request -> single AXI4-Lite transaction bridge. One request in flight;
// read data returns as a one-cycle pulse, non-OKAY responses latch a sticky err.
module vta_host_axil_master #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    input  logic                  req_opcode,
    input  logic [ADDR_BITS-1:0]  req_addr,
    input  logic [DATA_BITS-1:0]  req_value,
    output logic                  req_deq,
    output logic                  resp_valid,
    output logic [DATA_BITS-1:0]  resp_bits,
    output logic                  err,
    vta_host_axil_master_if.master m
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RDATA = 3'd4
    } state_t;

    state_t                 state_r;
    logic [ADDR_BITS-1:0]   addr_r;
    logic [DATA_BITS-1:0]   data_r;

    logic                   aw_fire_s;
    logic                   w_fire_s;
    logic                   wr_done_s;

    // Any response code other than OKAY counts as an error.
    function automatic logic resp_err(input logic [1:0] resp);
        return (resp != 2'b00);
    endfunction

    // Address and data come straight from the capture registers, so they are
    // stable for as long as the corresponding valid is high.
    assign m.m_awaddr = addr_r;
    assign m.m_araddr = addr_r;
    assign m.m_wdata  = data_r;
    assign m.m_wstrb  = {(DATA_BITS/8){1'b1}};

    assign aw_fire_s = m.m_awvalid & m.m_awready;
    assign w_fire_s  = m.m_wvalid  & m.m_wready;

    // A write channel is finished once its valid is gone or is being accepted now.
    always_comb begin
        wr_done_s = 1'b0;
        if ((!m.m_awvalid || aw_fire_s) && (!m.m_wvalid || w_fire_s)) begin
            wr_done_s = 1'b1;
        end else begin
            wr_done_s = 1'b0;
        end
    end

    // Transaction sequencer: owns every registered output of the bridge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            data_r      <= '0;
            req_deq     <= 1'b0;
            resp_valid  <= 1'b0;
            resp_bits   <= '0;
            err         <= 1'b0;
            m.m_awvalid <= 1'b0;
            m.m_wvalid  <= 1'b0;
            m.m_bready  <= 1'b0;
            m.m_arvalid <= 1'b0;
            m.m_rready  <= 1'b0;
        end else begin
            req_deq    <= 1'b0;
            resp_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_r  <= req_addr;
                        data_r  <= req_value;
                        req_deq <= 1'b1;
                        if (req_opcode) begin
                            m.m_awvalid <= 1'b1;
                            m.m_wvalid  <= 1'b1;
                            state_r     <= ST_WRITE;
                        end else begin
                            m.m_arvalid <= 1'b1;
                            state_r     <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (aw_fire_s) begin
                        m.m_awvalid <= 1'b0;
                    end
                    if (w_fire_s) begin
                        m.m_wvalid <= 1'b0;
                    end
                    if (wr_done_s) begin
                        m.m_bready <= 1'b1;
                        state_r    <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (m.m_bvalid && m.m_bready) begin
                        m.m_bready <= 1'b0;
                        err        <= err | resp_err(m.m_bresp);
                        state_r    <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (m.m_arvalid && m.m_arready) begin
                        m.m_arvalid <= 1'b0;
                        m.m_rready  <= 1'b1;
                        state_r     <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    // Erroring reads still hand their data back.
                    if (m.m_rvalid && m.m_rready) begin
                        m.m_rready <= 1'b0;
                        resp_bits  <= m.m_rdata;
                        resp_valid <= 1'b1;
                        err        <= err | resp_err(m.m_rresp);
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    m.m_awvalid <= 1'b0;
                    m.m_wvalid  <= 1'b0;
                    m.m_bready  <= 1'b0;
                    m.m_arvalid <= 1'b0;
                    m.m_rready  <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vta_host_axil_master.sv
// Directed bench for vta_host_axil_master: a table of request/slave-behaviour
// vectors driven through a cycle-level slave model, plus a mid-read reset sequence.
module tb_vta_host_axil_master;

    localparam int AB = 8;
    localparam int DB = 32;

    logic          clock;
    logic          reset_n;
    logic          req_valid;
    logic          req_opcode;
    logic [AB-1:0] req_addr;
    logic [DB-1:0] req_value;
    logic          req_deq;
    logic          resp_valid;
    logic [DB-1:0] resp_bits;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    vta_host_axil_master_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) axi ();

    vta_host_axil_master #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_opcode (req_opcode),
        .req_addr   (req_addr),
        .req_value  (req_value),
        .req_deq    (req_deq),
        .resp_valid (resp_valid),
        .resp_bits  (resp_bits),
        .err        (err),
        .m          (axi)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic          op;
        logic [AB-1:0] addr;
        logic [DB-1:0] value;
        int            aw_d;
        int            w_d;
        int            b_d;
        int            ar_d;
        int            r_d;
        logic [DB-1:0] rdata;
        logic [1:0]    rresp;
        logic [1:0]    bresp;
        int            hold;
        logic [DB-1:0] exp_bits;
        logic          exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one request and play the slave for it. Cycle offsets count negedge
    // samples from the cycle in which the req_deq pulse is visible.
    task automatic run_txn(input vec_t v, input int idx);
        int  cyc = 0;
        int  tail = -1;
        int  deq_n = 0, resp_n = 0, deq_cyc = -1, resp_cyc = -1, b_cyc = -1;
        int  aw_hi = 0, w_hi = 0, ar_hi = 0;
        int  aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
        int  aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0;
        int  hold_cnt = 0, viol = 0, exp_b;
        bit  aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
        bit  aw_got = 0, w_got = 0, ar_got = 0, b_done = 0, r_done = 0;
        bit  aw_pend = 0, w_pend = 0, ar_pend = 0;
        logic [DB-1:0] got_bits = '0, w_data = '0;
        logic [AB-1:0] aw_addr = '0, ar_addr = '0;
        logic [3:0]    w_strb = 4'h0;
        string tag;
        tag = $sformatf("v%0d", idx);
        req_valid  = 1'b1;
        req_opcode = v.op;
        req_addr   = v.addr;
        req_value  = v.value;
        while (tail != 0 && cyc < 80) begin
            @(negedge clock);
            if (aw_hs) aw_got = 1'b1;
            if (w_hs)  w_got  = 1'b1;
            if (ar_hs) ar_got = 1'b1;
            if (b_hs) begin axi.m_bvalid = 1'b0; b_done = 1'b1; end
            if (r_hs) begin axi.m_rvalid = 1'b0; r_done = 1'b1; end
            if (req_deq) begin deq_n++; if (deq_cyc < 0) deq_cyc = cyc; end
            if (resp_valid) begin resp_n++; resp_cyc = cyc; got_bits = resp_bits; end
            if (req_valid && deq_n > 0) begin
                if (hold_cnt >= v.hold) req_valid = 1'b0;
                else hold_cnt++;
            end
            if (axi.m_awvalid) begin
                if (aw_hi == 0) aw_addr = axi.m_awaddr;
                else if (axi.m_awaddr !== aw_addr) viol++;
                aw_hi++;
                axi.m_awready = (aw_cnt >= v.aw_d);
                aw_cnt++;
            end else begin
                if (aw_pend) viol++;
                axi.m_awready = 1'b0;
            end
            aw_hs = axi.m_awvalid && axi.m_awready;
            aw_pend = axi.m_awvalid && !aw_hs;
            if (aw_hs) aw_n++;
            if (axi.m_wvalid) begin
                if (w_hi == 0) begin w_data = axi.m_wdata; w_strb = axi.m_wstrb; end
                else if (axi.m_wdata !== w_data) viol++;
                w_hi++;
                axi.m_wready = (w_cnt >= v.w_d);
                w_cnt++;
            end else begin
                if (w_pend) viol++;
                axi.m_wready = 1'b0;
            end
            w_hs = axi.m_wvalid && axi.m_wready;
            w_pend = axi.m_wvalid && !w_hs;
            if (w_hs) w_n++;
            if (axi.m_arvalid) begin
                if (ar_hi == 0) ar_addr = axi.m_araddr;
                else if (axi.m_araddr !== ar_addr) viol++;
                ar_hi++;
                axi.m_arready = (ar_cnt >= v.ar_d);
                ar_cnt++;
            end else begin
                if (ar_pend) viol++;
                axi.m_arready = 1'b0;
            end
            ar_hs = axi.m_arvalid && axi.m_arready;
            ar_pend = axi.m_arvalid && !ar_hs;
            if (ar_hs) ar_n++;
            if (aw_got && w_got && !b_done && !axi.m_bvalid) begin
                if (b_cnt >= v.b_d) begin axi.m_bvalid = 1'b1; axi.m_bresp = v.bresp; end
                else b_cnt++;
            end
            b_hs = axi.m_bvalid && axi.m_bready;
            if (b_hs) begin b_n++; b_cyc = cyc; end
            if (ar_got && !r_done && !axi.m_rvalid) begin
                if (r_cnt >= v.r_d) begin
                    axi.m_rvalid = 1'b1; axi.m_rdata = v.rdata; axi.m_rresp = v.rresp;
                end else r_cnt++;
            end
            r_hs = axi.m_rvalid && axi.m_rready;
            if (r_hs) r_n++;
            if (tail > 0) tail--;
            else if (tail < 0 && (b_done || r_done)) tail = 4;
            cyc++;
        end
        req_valid = 1'b0;
        axi.m_bvalid = 1'b0;
        axi.m_rvalid = 1'b0;
        check({tag, " completed"}, 32'(tail == 0), 32'd1);
        check({tag, " deq_count"}, deq_n, 32'd1);
        check({tag, " err"}, 32'(err), 32'(v.exp_err));
        check({tag, " resp_bits"}, resp_bits, v.exp_bits);
        check({tag, " axi_rule_violations"}, viol, 32'd0);
        if (v.op) begin
            exp_b = ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d + 1;
            check({tag, " resp_count"}, resp_n, 32'd0);
            check({tag, " aw_hs"}, aw_n, 32'd1);
            check({tag, " w_hs"}, w_n, 32'd1);
            check({tag, " b_hs"}, b_n, 32'd1);
            check({tag, " ar_hs"}, ar_n, 32'd0);
            check({tag, " awaddr"}, 32'(aw_addr), 32'(v.addr));
            check({tag, " wdata"}, w_data, v.value);
            check({tag, " wstrb"}, 32'(w_strb), 32'h0000_000F);
            check({tag, " awvalid_cycles"}, aw_hi, v.aw_d + 1);
            check({tag, " wvalid_cycles"}, w_hi, v.w_d + 1);
            check({tag, " b_offset"}, b_cyc - deq_cyc, exp_b);
        end else begin
            check({tag, " resp_count"}, resp_n, 32'd1);
            check({tag, " ar_hs"}, ar_n, 32'd1);
            check({tag, " r_hs"}, r_n, 32'd1);
            check({tag, " aw_hs"}, aw_n, 32'd0);
            check({tag, " araddr"}, 32'(ar_addr), 32'(v.addr));
            check({tag, " arvalid_cycles"}, ar_hi, v.ar_d + 1);
            check({tag, " resp_offset"}, resp_cyc - deq_cyc, v.ar_d + v.r_d + 2);
            check({tag, " resp_pulse_data"}, got_bits, v.rdata);
        end
    endtask

    initial begin
        int waited;
        // op addr value aw w b ar r rdata rresp bresp hold exp_bits exp_err
        vecs[0] = '{1'b1, 8'h04, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00, 0, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 8'h08, 32'h0,         0, 0, 0, 0, 3, 32'h1234_5678, 2'b00, 2'b00, 0, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 8'h10, 32'hA5A5_0F0F, 4, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00, 0, 32'h1234_5678, 1'b0};
        vecs[3] = '{1'b1, 8'h14, 32'h0BAD_CAFE, 0, 3, 2, 0, 0, 32'h0, 2'b00, 2'b00, 0, 32'h1234_5678, 1'b0};
        vecs[4] = '{1'b0, 8'h0C, 32'h0,         0, 0, 0, 2, 0, 32'hCAFE_F00D, 2'b10, 2'b00, 0, 32'hCAFE_F00D, 1'b1};
        vecs[5] = '{1'b1, 8'h20, 32'h0000_0001, 0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00, 0, 32'hCAFE_F00D, 1'b1};
        vecs[6] = '{1'b1, 8'h24, 32'h55AA_55AA, 0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00, 2, 32'hCAFE_F00D, 1'b1};
        vecs[7] = '{1'b0, 8'h30, 32'h0,         0, 0, 0, 0, 0, 32'h0F1E_2D3C, 2'b00, 2'b00, 0, 32'h0F1E_2D3C, 1'b0};
        vecs[8] = '{1'b1, 8'h3C, 32'h1357_2468, 0, 0, 1, 0, 0, 32'h0, 2'b00, 2'b10, 0, 32'h0F1E_2D3C, 1'b1};

        reset_n = 1'b0;
        req_valid = 1'b0; req_opcode = 1'b0; req_addr = '0; req_value = '0;
        axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_arready = 1'b0;
        axi.m_bvalid = 1'b0; axi.m_bresp = 2'b00;
        axi.m_rvalid = 1'b0; axi.m_rdata = '0; axi.m_rresp = 2'b00;
        repeat (3) @(negedge clock);
        check("rst req_deq", 32'(req_deq), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst resp_bits", resp_bits, 32'd0);
        check("rst valids", {28'd0, axi.m_awvalid, axi.m_wvalid, axi.m_arvalid, 1'b0}, 32'd0);
        check("rst readies", {30'd0, axi.m_bready, axi.m_rready}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

        // Reset while a read address is waiting for arready.
        req_valid = 1'b1; req_opcode = 1'b0; req_addr = 8'h30;
        waited = 0;
        while (!axi.m_arvalid && waited < 20) begin
            @(negedge clock);
            if (req_deq) req_valid = 1'b0;
            waited++;
        end
        req_valid = 1'b0;
        check("rst6 arvalid_seen", 32'(axi.m_arvalid), 32'd1);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("rst6 arvalid_dropped", 32'(axi.m_arvalid), 32'd0);
        check("rst6 rready", 32'(axi.m_rready), 32'd0);
        check("rst6 err_cleared", 32'(err), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("rst6 no_resp_valid", 32'(resp_valid), 32'd0);
            check("rst6 no_arvalid", 32'(axi.m_arvalid), 32'd0);
        end

        for (int i = 7; i < 9; i++) run_txn(vecs[i], i);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
